// File: rtl/conv2d_seq_ctrl_pkg.sv
// Shared definitions for the 2-D convolution sequencer: state codes, defaults, sizing helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

    // Default geometry of the convolution engine
    localparam int DEF_IMG_W   = 8;
    localparam int DEF_IMG_H   = 8;
    localparam int DEF_K       = 3;
    localparam int DEF_STRIDE  = 1;
    localparam int DEF_MAC_LAT = 2;
    localparam int DEF_AW      = 6;

    // Sequencer state codes
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MAC   = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_EMIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Number of valid window positions along one axis
    function automatic int out_dim(input int img, input int k, input int stride);
        return (img - k) / stride + 1;
    endfunction

    // Counter/index width for n values; never narrower than one bit so K=1 or a
    // single output row/column still yields a legal port
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv2d_seq_ctrl_win_cnt.sv
// Nested window counters: kernel tap (kc inner, kr outer) and output pixel (ocol inner, orow outer).
// Latency: next-value outputs are combinational; the counters update on the following edge.
// Backpressure: advances only when the sequencer asserts tap_adv / pix_adv.
module conv_win_cnt import conv_pkg::*; #(
    parameter  int K     = DEF_K,
    parameter  int OUT_W = 6,
    parameter  int OUT_H = 6,
    localparam int KW    = cnt_w(K),
    localparam int CW    = cnt_w(OUT_W),
    localparam int RW    = cnt_w(OUT_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          tap_adv,
    input  logic          pix_adv,
    output logic [KW-1:0] kr_nx,
    output logic [KW-1:0] kc_nx,
    output logic [RW-1:0] orow_nx,
    output logic [CW-1:0] ocol_nx,
    output logic          last_tap,
    output logic          last_pixel
);

    logic [KW-1:0] kr;
    logic [KW-1:0] kc;
    logic [RW-1:0] orow;
    logic [CW-1:0] ocol;

    assign last_tap   = (kc == KW'(K - 1)) && (kr == KW'(K - 1));
    assign last_pixel = (ocol == CW'(OUT_W - 1)) && (orow == RW'(OUT_H - 1));

    // Next counter values: both pairs wrap to zero after their last position
    always_comb begin
        kr_nx   = kr;
        kc_nx   = kc;
        orow_nx = orow;
        ocol_nx = ocol;
        if (clr) begin
            kr_nx   = '0;
            kc_nx   = '0;
            orow_nx = '0;
            ocol_nx = '0;
        end else begin
            if (tap_adv) begin
                if (kc == KW'(K - 1)) begin
                    kc_nx = '0;
                    kr_nx = (kr == KW'(K - 1)) ? '0 : kr + KW'(1);
                end else begin
                    kc_nx = kc + KW'(1);
                end
            end
            if (pix_adv) begin
                if (ocol == CW'(OUT_W - 1)) begin
                    ocol_nx = '0;
                    orow_nx = (orow == RW'(OUT_H - 1)) ? '0 : orow + RW'(1);
                end else begin
                    ocol_nx = ocol + CW'(1);
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kr   <= '0;
            kc   <= '0;
            orow <= '0;
            ocol <= '0;
        end else begin
            kr   <= kr_nx;
            kc   <= kc_nx;
            orow <= orow_nx;
            ocol <= ocol_nx;
        end
    end

endmodule

// File: rtl/conv2d_seq_ctrl.sv
// 2-D convolution sequencer: walks output pixels in raster order, drives memory addresses and MAC controls.
// Latency: K*K + MAC_LAT + 1 cycles per pixel with out_ready high; all outputs registered.
// Backpressure: out_valid/out_row/out_col hold (MAC idle) until out_ready; abort overrides everything.
module conv2d_seq_ctrl import conv_pkg::*; #(
    parameter  int IMG_W   = DEF_IMG_W,
    parameter  int IMG_H   = DEF_IMG_H,
    parameter  int K       = DEF_K,
    parameter  int STRIDE  = DEF_STRIDE,
    parameter  int MAC_LAT = DEF_MAC_LAT,
    parameter  int AW      = DEF_AW,
    localparam int OUT_W   = out_dim(IMG_W, K, STRIDE),
    localparam int OUT_H   = out_dim(IMG_H, K, STRIDE),
    localparam int KAW     = cnt_w(K * K),
    localparam int KW      = cnt_w(K),
    localparam int RW      = cnt_w(OUT_H),
    localparam int CW      = cnt_w(OUT_W),
    localparam int FW      = cnt_w(MAC_LAT)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    output logic [AW-1:0]  img_addr,
    output logic [KAW-1:0] ker_addr,
    output logic           mac_en,
    output logic           acc_clr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [RW-1:0]  out_row,
    output logic [CW-1:0]  out_col,
    output logic           busy,
    output logic           done
);

    logic [2:0]     state;
    logic [2:0]     state_nx;
    logic [FW-1:0]  flush_cnt;
    logic [FW-1:0]  flush_nx;
    logic           tap_adv;
    logic           pix_adv;
    logic [KW-1:0]  kr_nx;
    logic [KW-1:0]  kc_nx;
    logic [RW-1:0]  orow_nx;
    logic [CW-1:0]  ocol_nx;
    logic           last_tap;
    logic           last_pixel;
    logic [AW-1:0]  img_nx;
    logic [KAW-1:0] ker_nx;

    conv_win_cnt #(
        .K     (K),
        .OUT_W (OUT_W),
        .OUT_H (OUT_H)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (abort),
        .tap_adv    (tap_adv),
        .pix_adv    (pix_adv),
        .kr_nx      (kr_nx),
        .kc_nx      (kc_nx),
        .orow_nx    (orow_nx),
        .ocol_nx    (ocol_nx),
        .last_tap   (last_tap),
        .last_pixel (last_pixel)
    );

    // Addresses for the tap being issued next cycle; full 32-bit math, then truncated
    assign img_nx = AW'((32'(orow_nx) * 32'(STRIDE) + 32'(kr_nx)) * 32'(IMG_W)
                        + 32'(ocol_nx) * 32'(STRIDE) + 32'(kc_nx));
    assign ker_nx = KAW'(32'(kr_nx) * 32'(K) + 32'(kc_nx));

    // Next-state and counter-advance decisions; abort wins over everything
    always_comb begin
        state_nx = state;
        flush_nx = flush_cnt;
        tap_adv  = 1'b0;
        pix_adv  = 1'b0;
        if (abort) begin
            state_nx = ST_IDLE;
            flush_nx = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state_nx = ST_MAC;
                end
                ST_MAC: begin
                    tap_adv = 1'b1;
                    if (last_tap) begin
                        state_nx = (MAC_LAT == 0) ? ST_EMIT : ST_FLUSH;
                        flush_nx = '0;
                    end
                end
                ST_FLUSH: begin
                    flush_nx = flush_cnt + FW'(1);
                    if (flush_cnt == FW'(MAC_LAT - 1)) state_nx = ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        pix_adv  = 1'b1;
                        state_nx = last_pixel ? ST_DONE : ST_MAC;
                    end
                end
                ST_DONE: begin
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // State register plus registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flush_cnt <= '0;
            img_addr  <= '0;
            ker_addr  <= '0;
            mac_en    <= 1'b0;
            acc_clr   <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_nx;
            mac_en    <= (state_nx == ST_MAC);
            acc_clr   <= (state_nx == ST_MAC) && (kr_nx == '0) && (kc_nx == '0);
            img_addr  <= (state_nx == ST_MAC) ? img_nx : '0;
            ker_addr  <= (state_nx == ST_MAC) ? ker_nx : '0;
            out_valid <= (state_nx == ST_EMIT);
            out_row   <= (state_nx == ST_EMIT) ? orow_nx : '0;
            out_col   <= (state_nx == ST_EMIT) ? ocol_nx : '0;
            busy      <= (state_nx != ST_IDLE);
            done      <= (state_nx == ST_DONE);
        end
    end

endmodule

// File: tb/tb_conv2d_seq_ctrl.sv
// Bench for conv2d_seq_ctrl: three geometries share a clock; a schedule model predicts every output.
// Latency: n/a.
// Backpressure: out_ready driven randomly or held low for directed stretches.
module tb_conv2d_seq_ctrl;

    // Geometries: 0 = 4x4 K3 S1 L2, 1 = 8x8 K3 S2 L2, 2 = 2x2 K1 S1 L0
    localparam int P_W[3] = '{4, 8, 2};
    localparam int P_H[3] = '{4, 8, 2};
    localparam int P_K[3] = '{3, 3, 1};
    localparam int P_S[3] = '{1, 2, 1};
    localparam int P_L[3] = '{2, 2, 0};

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    logic       abort;
    logic       out_ready;

    logic [2:0] mac_en_v, acc_clr_v, out_valid_v, busy_v, done_v;
    logic [3:0] img0;  logic [3:0] ker0;  logic [0:0] row0;  logic [0:0] col0;
    logic [5:0] img1;  logic [3:0] ker1;  logic [1:0] row1;  logic [1:0] col1;
    logic [1:0] img2;  logic [0:0] ker2;  logic [0:0] row2;  logic [0:0] col2;

    int sel;
    logic o_mac, o_clr, o_val, o_busy, o_done;
    logic [31:0] o_img, o_ker, o_row, o_col;

    int checks = 0;
    int errors = 0;

    conv2d_seq_ctrl #(.IMG_W(4), .IMG_H(4), .K(3), .STRIDE(1), .MAC_LAT(2), .AW(4)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort),
        .img_addr(img0), .ker_addr(ker0), .mac_en(mac_en_v[0]), .acc_clr(acc_clr_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready), .out_row(row0), .out_col(col0),
        .busy(busy_v[0]), .done(done_v[0]));

    conv2d_seq_ctrl #(.IMG_W(8), .IMG_H(8), .K(3), .STRIDE(2), .MAC_LAT(2), .AW(6)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort),
        .img_addr(img1), .ker_addr(ker1), .mac_en(mac_en_v[1]), .acc_clr(acc_clr_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready), .out_row(row1), .out_col(col1),
        .busy(busy_v[1]), .done(done_v[1]));

    conv2d_seq_ctrl #(.IMG_W(2), .IMG_H(2), .K(1), .STRIDE(1), .MAC_LAT(0), .AW(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort),
        .img_addr(img2), .ker_addr(ker2), .mac_en(mac_en_v[2]), .acc_clr(acc_clr_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready), .out_row(row2), .out_col(col2),
        .busy(busy_v[2]), .done(done_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the selected instance onto common observation signals
    always_comb begin
        o_mac  = mac_en_v[sel];
        o_clr  = acc_clr_v[sel];
        o_val  = out_valid_v[sel];
        o_busy = busy_v[sel];
        o_done = done_v[sel];
        case (sel)
            0:       begin o_img = 32'(img0); o_ker = 32'(ker0); o_row = 32'(row0); o_col = 32'(col0); end
            1:       begin o_img = 32'(img1); o_ker = 32'(ker1); o_row = 32'(row1); o_col = 32'(col1); end
            default: begin o_img = 32'(img2); o_ker = 32'(ker2); o_row = 32'(row2); o_col = 32'(col2); end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input bit with_rc);
        chk({tag, "_mac_en"},    32'(o_mac),  0);
        chk({tag, "_acc_clr"},   32'(o_clr),  0);
        chk({tag, "_img_addr"},  o_img,       0);
        chk({tag, "_ker_addr"},  o_ker,       0);
        chk({tag, "_out_valid"}, 32'(o_val),  0);
        chk({tag, "_busy"},      32'(o_busy), 0);
        chk({tag, "_done"},      32'(o_done), 0);
        if (with_rc) begin
            chk({tag, "_out_row"}, o_row, 0);
            chk({tag, "_out_col"}, o_col, 0);
        end
    endtask

    // One frame on geometry cfg. Pixel p issues taps at cycles s..s+K*K-1, is presented from
    // s+K*K+MAC_LAT until taken at h, and the next pixel starts at h+1; done follows the last h.
    // Cycle 0 is the first observation after the edge that sampled start.
    task automatic frame(input int cfg, input int pct, input bit hold, input int abort_at,
                         input int rst_at, output int dc_obs, output int last_a);
        int w, kk1, s_, lat, ow, oh, np, kk, p, s, c, done_c, vcnt, rel, orow, ocol, t, kr, kc;
        bit mac_x, val_x, rdy, fin;
        w = P_W[cfg]; kk1 = P_K[cfg]; s_ = P_S[cfg]; lat = P_L[cfg];
        ow = (P_W[cfg] - kk1) / s_ + 1;
        oh = (P_H[cfg] - kk1) / s_ + 1;
        np = ow * oh; kk = kk1 * kk1;
        sel = cfg;
        dc_obs = -1; last_a = -1;
        p = 0; s = 0; c = 0; done_c = 1 << 30; vcnt = 0; fin = 1'b0;
        @(negedge clk);
        start_v[cfg] = 1'b1;
        out_ready    = 1'b1;
        @(negedge clk);
        start_v[cfg] = 1'b0;
        while (!fin) begin
            rel   = c - s;
            mac_x = (p < np) && (rel < kk);
            val_x = (p < np) && (rel >= kk + lat);
            orow  = (p < np) ? p / ow : 0;
            ocol  = (p < np) ? p % ow : 0;
            t     = mac_x ? rel : 0;
            kr    = t / kk1;
            kc    = t % kk1;
            chk("mac_en",    32'(o_mac), 32'(mac_x));
            chk("acc_clr",   32'(o_clr), 32'(mac_x && (t == 0)));
            chk("img_addr",  o_img, mac_x ? 32'((orow * s_ + kr) * w + ocol * s_ + kc) : 0);
            chk("ker_addr",  o_ker, mac_x ? 32'(kr * kk1 + kc) : 0);
            chk("out_valid", 32'(o_val), 32'(val_x));
            if (val_x) begin
                chk("out_row", o_row, 32'(orow));
                chk("out_col", o_col, 32'(ocol));
            end
            chk("busy", 32'(o_busy), 32'((p < np) || (c == done_c)));
            chk("done", 32'(o_done), 32'(c == done_c));
            if (o_done === 1'b1 && dc_obs < 0) dc_obs = c;
            if (mac_x && t == 0 && p == np - 1) last_a = int'(o_img);
            if (c == abort_at) begin
                abort        = 1'b1;
                start_v[cfg] = 1'b1;
                @(negedge clk);
                chk_quiet("abort", 1'b0);
                @(negedge clk);
                chk("start_abort_idle_busy", 32'(o_busy), 0);
                chk("start_abort_idle_mac",  32'(o_mac),  0);
                abort        = 1'b0;
                start_v[cfg] = 1'b0;
                fin = 1'b1;
            end else if (c == rst_at) begin
                rst_n        = 1'b0;
                start_v[cfg] = 1'b0;
                @(negedge clk);
                chk_quiet("rst_mid", 1'b1);
                rst_n = 1'b1;
                fin = 1'b1;
            end else if (c > done_c) begin
                start_v[cfg] = 1'b0;
                fin = 1'b1;
            end else begin
                rdy = ($urandom_range(99) < pct);
                if (hold && val_x && vcnt < 5) rdy = 1'b0;
                out_ready    = rdy;
                start_v[cfg] = ($urandom_range(3) == 0);
                if (val_x) begin
                    vcnt++;
                    if (rdy) begin
                        p++;
                        s = c + 1;
                        vcnt = 0;
                        if (p == np) done_c = c + 1;
                    end
                end
                @(negedge clk);
                c++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, la;
        sel       = 0;
        rst_n     = 1'b0;
        start_v   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            chk_quiet("reset", 1'b1);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Full-rate frames: exact frame lengths and spot addresses of the last pixel
        frame(0, 100, 1'b0, -1, -1, dc, la);
        chk("c0_done_cycle", 32'(dc), 48);
        chk("c0_pix11_addr", 32'(la), 5);
        frame(1, 100, 1'b0, -1, -1, dc, la);
        chk("c1_done_cycle", 32'(dc), 108);
        chk("c1_pix22_addr", 32'(la), 36);
        frame(2, 100, 1'b0, -1, -1, dc, la);
        chk("c2_done_cycle", 32'(dc), 8);
        chk("c2_pix11_addr", 32'(la), 3);

        // Backpressure: five held cycles per pixel, then random ready
        frame(0, 60, 1'b1, -1, -1, dc, la);
        frame(1, 50, 1'b0, -1, -1, dc, la);

        // Abort mid-MAC of the second pixel, then a clean restart from pixel (0,0)
        frame(0, 100, 1'b0, 14, -1, dc, la);
        frame(0, 100, 1'b0, -1, -1, dc, la);
        chk("restart_done_cycle", 32'(dc), 48);

        // Reset while presenting the first pixel
        frame(0, 100, 1'b0, -1, 11, dc, la);
        frame(2, 50, 1'b0, -1, -1, dc, la);
        frame(1, 70, 1'b1, -1, -1, dc, la);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
